// File: rtl/brick_game_ctrl.sv
// brick_game_ctrl -- brick-breaker game controller on a 16x12 playfield.
// Holds the game state machine (IDLE/SERVE/RUN/OVER), the plate position,
// the ball position/direction, the 7x8 brick field, the score and the lives.
// Optional macro: BRICK_LIVES_EN (three lives per game instead of one).
module brick_game_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        move_left,
  input  logic        move_right,
  output logic [15:0] plate_row,
  output logic [3:0]  ball_rowIndex,
  output logic [3:0]  ball_colIndex,
  output logic [55:0] bricks,
  output logic        IsGameOver,
  output logic        win,
  output logic [5:0]  score,
  output logic [1:0]  lives
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam logic [3:0] POS_HOME = 4'd6;
  localparam logic [3:0] POS_MAX  = 4'd12;
  localparam logic [3:0] ROW_SERVE = 4'd9;
  localparam logic [3:0] ROW_MISS  = 4'd11;

`ifdef BRICK_LIVES_EN
  localparam logic [1:0] LIVES_RELOAD = 2'd3;
`else
  localparam logic [1:0] LIVES_RELOAD = 2'd1;
`endif

  logic [1:0]  state_q, state_d;
  logic [3:0]  pos_q, pos_d;
  logic [3:0]  row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic        dx_q, dx_d;      // 1: moving right (+1), 0: moving left (-1)
  logic        dy_q, dy_d;      // 1: moving down (+1),  0: moving up (-1)
  logic [55:0] bricks_q, bricks_d;
  logic [5:0]  score_q, score_d;
  logic        win_q, win_d;
`ifdef BRICK_LIVES_EN
  logic [1:0]  lives_q, lives_d;
`endif

  logic [3:0]  pos_step;
  logic [3:0]  nc, nr;
  logic        dx_new, dy_new;
  logic [5:0]  brick_idx;
  logic [63:0] bricks_pad;
  logic [55:0] hit_mask, bricks_after;
  logic        brick_hit, plate_hit, miss;

  // Candidate plate move and candidate ball step (walls, ceiling, brick, plate)
  always_comb begin
    pos_step = pos_q;
    if (move_left && !move_right && pos_q != 4'd0)
      pos_step = pos_q - 4'd1;
    else if (move_right && !move_left && pos_q != POS_MAX)
      pos_step = pos_q + 4'd1;

    // Side walls: a step that would leave 0..15 reflects in place.
    dx_new = dx_q;
    nc     = col_q;
    if (dx_q) begin
      if (col_q == 4'd15) begin dx_new = 1'b0; nc = 4'd14; end
      else                  nc = col_q + 4'd1;
    end else begin
      if (col_q == 4'd0)  begin dx_new = 1'b1; nc = 4'd1; end
      else                  nc = col_q - 4'd1;
    end

    // Ceiling: moving up from row 0 turns the ball down into row 1.
    dy_new = dy_q;
    nr     = row_q + 4'd1;
    if (!dy_q) begin
      if (row_q == 4'd0) begin dy_new = 1'b1; nr = 4'd1; end
      else                 nr = row_q - 4'd1;
    end

    // Bricks are two columns wide; index = row*8 + col/2 (rows 0..6 only).
    brick_idx    = {nr[2:0], nc[3:1]};
    bricks_pad   = {8'h00, bricks_q};
    hit_mask     = 56'd1 << brick_idx;
    brick_hit    = (nr <= 4'd6) && bricks_pad[brick_idx];
    bricks_after = bricks_q & ~hit_mask;
    // The plate is judged at its registered position, i.e. what the player sees.
    plate_hit    = dy_new && (row_q == ROW_SERVE) && (nc >= pos_q) && (nc <= pos_q + 4'd3);
    miss         = (nr == ROW_MISS);
  end

  // Next-state logic for the game state machine and all game registers
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    row_d    = row_q;
    col_d    = col_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    bricks_d = bricks_q;
    score_d  = score_q;
    win_d    = win_q;
`ifdef BRICK_LIVES_EN
    lives_d  = lives_q;
`endif
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d  = S_SERVE;
          bricks_d = '1;
          score_d  = '0;
          pos_d    = POS_HOME;
          dx_d     = 1'b1;
          dy_d     = 1'b0;
          win_d    = 1'b0;
`ifdef BRICK_LIVES_EN
          lives_d  = LIVES_RELOAD;
`endif
        end
      end
      S_SERVE: begin
        if (tick) pos_d = pos_step;
        // The ball leaves from where it was shown, on the pre-move plate.
        if (start) begin
          state_d = S_RUN;
          row_d   = ROW_SERVE;
          col_d   = pos_q + 4'd1;
          dx_d    = 1'b1;
          dy_d    = 1'b0;
        end
      end
      default: begin // S_RUN
        if (tick) begin
          pos_d = pos_step;
          dx_d  = dx_new;
          col_d = nc;
          if (brick_hit) begin
            bricks_d = bricks_after;
            score_d  = score_q + 6'd1;
            dy_d     = ~dy_new;
            if (bricks_after == '0) begin
              state_d = S_OVER;
              win_d   = 1'b1;
            end
          end else if (plate_hit) begin
            dy_d = 1'b0;
          end else begin
            row_d = nr;
            dy_d  = dy_new;
            if (miss) begin
`ifdef BRICK_LIVES_EN
              lives_d = lives_q - 2'd1;
              if (lives_q > 2'd1) begin
                state_d = S_SERVE;
                dx_d    = 1'b1;
                dy_d    = 1'b0;
              end else begin
                state_d = S_OVER;
                win_d   = 1'b0;
              end
`else
              state_d = S_OVER;
              win_d   = 1'b0;
`endif
            end
          end
        end
      end
    endcase
  end

  // State registers with asynchronous reset to the idle game
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pos_q    <= POS_HOME;
      row_q    <= ROW_SERVE;
      col_q    <= 4'd7;
      dx_q     <= 1'b1;
      dy_q     <= 1'b0;
      bricks_q <= '1;
      score_q  <= '0;
      win_q    <= 1'b0;
`ifdef BRICK_LIVES_EN
      lives_q  <= LIVES_RELOAD;
`endif
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      row_q    <= row_d;
      col_q    <= col_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      bricks_q <= bricks_d;
      score_q  <= score_d;
      win_q    <= win_d;
`ifdef BRICK_LIVES_EN
      lives_q  <= lives_d;
`endif
    end
  end

  // While serving, the ball rides on the plate at column pos+1.
  assign ball_rowIndex = (state_q == S_SERVE) ? ROW_SERVE : row_q;
  assign ball_colIndex = (state_q == S_SERVE) ? (pos_q + 4'd1) : col_q;
  assign plate_row     = 16'h000F << pos_q;
  assign bricks        = bricks_q;
  assign IsGameOver    = (state_q == S_OVER);
  assign win           = win_q;
  assign score         = score_q;
`ifdef BRICK_LIVES_EN
  assign lives         = lives_q;
`else
  assign lives         = LIVES_RELOAD;
`endif

endmodule

// File: tb/tb_brick_game_ctrl.sv
// tb_brick_game_ctrl -- table-driven, hand-sequence and randomized checks of
// brick_game_ctrl against a behavioural game model kept in the bench.
module tb_brick_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0, start = 1'b0, move_left = 1'b0, move_right = 1'b0;
  logic [15:0] plate_row;
  logic [3:0]  ball_rowIndex, ball_colIndex;
  logic [55:0] bricks;
  logic        IsGameOver, win;
  logic [5:0]  score;
  logic [1:0]  lives;

  brick_game_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .move_left(move_left), .move_right(move_right),
    .plate_row(plate_row), .ball_rowIndex(ball_rowIndex), .ball_colIndex(ball_colIndex),
    .bricks(bricks), .IsGameOver(IsGameOver), .win(win), .score(score), .lives(lives)
  );

  always #5 clk = ~clk;

`ifdef BRICK_LIVES_EN
  localparam int RELOAD = 3;
`else
  localparam int RELOAD = 1;
`endif

  int checks = 0;
  int errors = 0;
  int wins_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural game model ----------------
  localparam int M_IDLE = 0, M_SERVE = 1, M_RUN = 2, M_OVER = 3;
  int m_state, m_pos, m_r, m_c, m_dx, m_dy, m_score, m_lives;
  bit m_win;
  bit m_bricks[56];

  function automatic int m_left();
    int n = 0;
    for (int i = 0; i < 56; i++) n += int'(m_bricks[i]);
    return n;
  endfunction

  function automatic void m_new_field();
    for (int i = 0; i < 56; i++) m_bricks[i] = 1'b1;
    m_score = 0;
    m_lives = RELOAD;
    m_pos = 6;
    m_dx = 1;
    m_dy = -1;
    m_win = 1'b0;
  endfunction

  function automatic void m_reset();
    m_state = M_IDLE;
    m_r = 9;
    m_c = 7;
    m_new_field();
  endfunction

  function automatic void m_move(input bit l, input bit r);
    if (l && !r && m_pos > 0) m_pos--;
    if (r && !l && m_pos < 12) m_pos++;
  endfunction

  function automatic void m_ball(input int p);
    int nc, nr;
    nc = m_c + m_dx;
    if (nc < 0 || nc > 15) begin
      m_dx = -m_dx;
      nc = m_c + m_dx;
    end
    nr = m_r + m_dy;
    if (m_r == 0 && m_dy == -1) begin
      m_dy = 1;
      nr = 1;
    end
    if (nr <= 6 && m_bricks[nr * 8 + nc / 2]) begin
      m_bricks[nr * 8 + nc / 2] = 1'b0;
      m_score++;
      m_dy = -m_dy;
      m_c = nc;
      if (m_left() == 0) begin
        m_state = M_OVER;
        m_win = 1'b1;
      end
    end else if (m_dy == 1 && m_r == 9 && nc >= p && nc <= p + 3) begin
      m_dy = -1;
      m_c = nc;
    end else begin
      m_r = nr;
      m_c = nc;
      if (nr == 11) begin
`ifdef BRICK_LIVES_EN
        m_lives--;
        if (m_lives > 0) begin
          m_state = M_SERVE;
          m_dx = 1;
          m_dy = -1;
        end else begin
          m_state = M_OVER;
          m_win = 1'b0;
        end
`else
        m_state = M_OVER;
        m_win = 1'b0;
`endif
      end
    end
  endfunction

  function automatic void m_step(input bit t, input bit s, input bit l, input bit r);
    int old_pos;
    old_pos = m_pos;
    case (m_state)
      M_IDLE, M_OVER: if (s) begin m_state = M_SERVE; m_new_field(); end
      M_SERVE: begin
        if (t) m_move(l, r);
        if (s) begin
          m_state = M_RUN;
          m_r = 9;
          m_c = old_pos + 1;
          m_dx = 1;
          m_dy = -1;
        end
      end
      default: if (t) begin m_move(l, r); m_ball(old_pos); end
    endcase
  endfunction

  task automatic check_model(input string tag);
    logic [55:0] bv;
    int er, ec, plate;
    for (int i = 0; i < 56; i++) bv[i] = m_bricks[i];
    er = (m_state == M_SERVE) ? 9 : m_r;
    ec = (m_state == M_SERVE) ? m_pos + 1 : m_c;
    plate = (1 << (m_pos + 4)) - (1 << m_pos);
    chk({tag, " row"},    64'(ball_rowIndex), 64'(er));
    chk({tag, " col"},    64'(ball_colIndex), 64'(ec));
    chk({tag, " plate"},  64'(plate_row),     64'(plate));
    chk({tag, " bricks"}, 64'(bricks),        64'(bv));
    chk({tag, " score"},  64'(score),         64'(m_score));
    chk({tag, " lives"},  64'(lives),         64'(m_lives));
    chk({tag, " over"},   64'(IsGameOver),    64'(m_state == M_OVER));
    chk({tag, " win"},    64'(win),           64'(m_win));
  endtask

  // One clock with the given inputs; the model steps on the same edge.
  task automatic cycle(input bit t, input bit s, input bit l, input bit r);
    @(negedge clk);
    tick = t; start = s; move_left = l; move_right = r;
    @(posedge clk);
    m_step(t, s, l, r);
    #1;
    tick = 1'b0; start = 1'b0; move_left = 1'b0; move_right = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit t, s, l, r;
    logic [3:0]  row, col;
    logic [15:0] plate;
    logic [5:0]  score;
    logic [1:0]  lives;
    logic        over;
  } vec_t;

  vec_t vecs[14];
  int target, off;
  bit t, s, l, r;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd9,  4'd7,  16'h03C0, 6'd0, 2'(RELOAD), 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd9,  4'd7,  16'h03C0, 6'd0, 2'(RELOAD), 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd9,  4'd6,  16'h01E0, 6'd0, 2'(RELOAD), 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd9,  4'd6,  16'h01E0, 6'd0, 2'(RELOAD), 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd9,  4'd7,  16'h03C0, 6'd0, 2'(RELOAD), 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd9,  4'd7,  16'h03C0, 6'd0, 2'(RELOAD), 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd8,  4'd8,  16'h03C0, 6'd0, 2'(RELOAD), 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd7,  4'd9,  16'h0780, 6'd0, 2'(RELOAD), 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd7,  4'd10, 16'h0780, 6'd1, 2'(RELOAD), 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd8,  4'd11, 16'h0780, 6'd1, 2'(RELOAD), 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd9,  4'd12, 16'h0780, 6'd1, 2'(RELOAD), 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd10, 4'd13, 16'h0780, 6'd1, 2'(RELOAD), 1'b0};
`ifdef BRICK_LIVES_EN
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd9,  4'd8,  16'h0780, 6'd1, 2'd2, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd9,  4'd8,  16'h0780, 6'd1, 2'd2, 1'b0};
`else
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd11, 4'd14, 16'h0780, 6'd1, 2'd1, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd11, 4'd14, 16'h0780, 6'd1, 2'd1, 1'b1};
`endif

    // Reset values
    m_reset();
    #12;
    chk("reset plate",  64'(plate_row),     64'h03C0);
    chk("reset bricks", 64'(bricks),        64'h00FF_FFFF_FFFF_FFFF);
    chk("reset row",    64'(ball_rowIndex), 64'd9);
    chk("reset col",    64'(ball_colIndex), 64'd7);
    chk("reset over",   64'(IsGameOver),    64'd0);
    chk("reset lives",  64'(lives),         64'(RELOAD));
    @(negedge clk);
    rst = 1'b0;

    // Table: serve, plate moves, launch, brick hit, miss
    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].t, vecs[i].s, vecs[i].l, vecs[i].r);
      $display("vec %0d in t=%0d s=%0d l=%0d r=%0d -> ball (%0d,%0d) plate %h score %0d lives %0d over %0d",
               i, vecs[i].t, vecs[i].s, vecs[i].l, vecs[i].r, ball_rowIndex, ball_colIndex,
               plate_row, score, lives, IsGameOver);
      chk($sformatf("vec%0d row", i),   64'(ball_rowIndex), 64'(vecs[i].row));
      chk($sformatf("vec%0d col", i),   64'(ball_colIndex), 64'(vecs[i].col));
      chk($sformatf("vec%0d plate", i), 64'(plate_row),     64'(vecs[i].plate));
      chk($sformatf("vec%0d score", i), 64'(score),         64'(vecs[i].score));
      chk($sformatf("vec%0d lives", i), 64'(lives),         64'(vecs[i].lives));
      chk($sformatf("vec%0d over", i),  64'(IsGameOver),    64'(vecs[i].over));
    end
    chk("vec brick53", 64'(bricks[53]), 64'd0);

    // Hand sequence: corner brick, right-wall reflection, plate bounce
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    chk("serve col at pos11", 64'(ball_colIndex), 64'd12);
    chk("serve plate pos11",  64'(plate_row),     64'h7800);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    $display("seq corner ball (%0d,%0d) score %0d", ball_rowIndex, ball_colIndex, score);
    chk("corner row",     64'(ball_rowIndex), 64'd7);
    chk("corner col",     64'(ball_colIndex), 64'd15);
    chk("corner brick55", 64'(bricks[55]),    64'd0);
    chk("corner score",   64'(score),         64'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    $display("seq wall ball (%0d,%0d)", ball_rowIndex, ball_colIndex);
    chk("wall row", 64'(ball_rowIndex), 64'd8);
    chk("wall col", 64'(ball_colIndex), 64'd14);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    $display("seq bounce ball (%0d,%0d)", ball_rowIndex, ball_colIndex);
    chk("bounce row", 64'(ball_rowIndex), 64'd9);
    chk("bounce col", 64'(ball_colIndex), 64'd12);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);  // start in RUN is ignored
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    $display("seq rebound ball (%0d,%0d)", ball_rowIndex, ball_colIndex);
    chk("rebound row", 64'(ball_rowIndex), 64'd8);
    chk("rebound col", 64'(ball_colIndex), 64'd11);
    check_model("seq");

    // Asynchronous reset between clock edges, mid-RUN
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset ball (%0d,%0d) plate %h score %0d", ball_rowIndex, ball_colIndex, plate_row, score);
    chk("async plate",  64'(plate_row),     64'h03C0);
    chk("async row",    64'(ball_rowIndex), 64'd9);
    chk("async col",    64'(ball_colIndex), 64'd7);
    chk("async bricks", 64'(bricks),        64'h00FF_FFFF_FFFF_FFFF);
    chk("async score",  64'(score),         64'd0);
    chk("async over",   64'(IsGameOver),    64'd0);
    chk("async win",    64'(win),           64'd0);
    chk("async lives",  64'(lives),         64'(RELOAD));
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b1);  // tick in IDLE is ignored
    check_model("idle tick");

    // Randomized play with a plate that mostly chases the ball
    off = 1;
    for (int n = 0; n < 8000; n++) begin
      t = ($urandom_range(3) != 0);
      s = (m_state == M_RUN) ? ($urandom_range(15) == 0) : ($urandom_range(5) == 0);
      if ($urandom_range(9) < 8) begin
        target = m_c - off;
        l = (m_pos > target);
        r = (m_pos < target);
      end else begin
        l = 1'($urandom_range(1));
        r = 1'($urandom_range(1));
      end
      if ($urandom_range(63) == 0) off = $urandom_range(3);
      cycle(t, s, l, r);
      check_model($sformatf("rand%0d", n));
      if (m_state == M_OVER && m_win && s) wins_seen++;
    end
    $display("random phase done, final score %0d, restarts after win %0d", m_score, wins_seen);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/brick_game_ctrl.md
BRICK_GAME_CTRL -- requirements
Module: brick_game_ctrl

Interface
REQ-001 The module SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 The module SHALL have these ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- tick  in  1  one-cycle game-step pulse.
- start  in  1  one-cycle start/serve pulse.
- move_left  in  1  plate left request, sampled on tick.
- move_right  in  1  plate right request, sampled on tick.
- plate_row  out  16  plate bitmap for row 10.
- ball_rowIndex  out  4  ball row, 0..11, with 0 at the top.
- ball_colIndex  out  4  ball column, 0..15.
- bricks  out  56  brick-present flags; index = row*8 + col/2, rows 0..6.
- IsGameOver  out  1  high in the OVER state.
- win  out  1  high when OVER was reached by clearing all bricks.
- score  out  6  number of bricks destroyed.
- lives  out  2  lives remaining.

Function
REQ-003 The state machine SHALL have four states: IDLE, SERVE, RUN and OVER; every transition SHALL be registered.
REQ-004 Plate position pos SHALL range 0..12; plate_row SHALL equal 4'b1111 shifted left by pos.
REQ-005 On tick in SERVE or RUN, pos SHALL decrement for move_left alone (floor 0), increment for move_right alone (ceiling 12), and hold when both or neither are asserted.
REQ-006 Transitions out of IDLE and OVER:
- start SHALL move to SERVE.
- On entry to SERVE from IDLE or OVER: bricks = all ones, score = 0, lives reloaded, pos = 6.
REQ-007 SERVE behaviour:
- Ball row SHALL be 9 and ball col SHALL be pos+1, tracking the plate combinationally from registered pos.
- Direction SHALL be dx = +1, dy = -1.
- start SHALL move to RUN.
- If start and tick coincide, pos updates and the ball does not step that cycle.
REQ-008 In RUN, each tick SHALL perform exactly one ball step:
- nc = col + dx; if nc falls outside 0..15, dx is negated and nc = col - dx.
- nr = row + dy.
- Row 0 with dy = -1: dy SHALL become +1 and nr = 1.
REQ-009 Brick hit, checked after wall reflection: if nr <= 6 and bricks[nr*8 + nc/2] = 1, then:
- That bit SHALL clear.
- score SHALL increment.
- dy SHALL negate.
- Row SHALL stay unchanged and col SHALL become nc.
REQ-010 Plate bounce: if dy = +1, row = 9 and pos <= nc <= pos+3, dy SHALL become -1, row SHALL stay 9 and col SHALL become nc.
REQ-011 If none of REQ-009/REQ-010 applies, the ball SHALL move to (nr, nc).
REQ-012 A ball reaching row 11 SHALL be a miss, handled at that tick.
REQ-013 A brick hit that clears the last brick SHALL move to OVER with win = 1; this takes priority over any other event in the same tick.
REQ-014 In OVER, IsGameOver SHALL be 1, and ball and bricks SHALL hold their values.
REQ-015 tick outside SERVE and RUN SHALL be ignored; start in RUN SHALL be ignored.

Reset
REQ-016 Reset SHALL force the following values, asynchronously:
- state = IDLE.
- pos = 6, plate_row = 16'h03C0.
- ball row 9, col 7, dx = +1, dy = -1.
- bricks = all ones, score = 0.
- IsGameOver = 0, win = 0.
- lives = reload value.
REQ-017 Reset asserted mid-RUN SHALL abandon the game with no residual state.

Configuration
REQ-018 Macro BRICK_LIVES_EN SHALL select the lives behaviour.
- Defined: reload value is 3; a miss decrements lives, goes to SERVE with bricks and score kept if lives > 0 afterwards, and goes to OVER with win = 0 otherwise.
- Undefined: lives is constant 1; any miss goes to OVER with win = 0.

Verification
REQ-019 Reset -> state IDLE, plate_row = 16'h03C0, bricks = 56'hFFFFFFFFFFFFFF, ball (9,7), IsGameOver = 0.
REQ-020 start, start, tick -> RUN; ball at (8,8).
REQ-021 Ball at col 15, dx = +1, tick -> col 14, dx = -1, row advances by dy.
REQ-022 Ball at (7,4), dx = +1, dy = -1, brick 50 present, tick -> bricks[50] = 0, ball (7,5), dy = +1, score + 1.
REQ-023 Ball at (9,0), dy = +1, pos = 12 -> after two ticks IsGameOver = 1, win = 0 (undefined macro); with BRICK_LIVES_EN, lives 3 -> 2 and state SERVE.
REQ-024 rst pulsed mid-RUN, asynchronously between clock edges -> all REQ-016 values immediately.
